// File: rtl/mv_stream_driver_if.sv
// Handshake and multiplier-bus bundle for the matrix-vector stream driver.
// The master side is the driver; the slave side is the source, the result consumer and the multiplier.
interface mv_stream_driver_if;
    logic [5:0] in_vec;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bus_out;
    logic [7:0] bus_in;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;

    modport master (
        input  in_vec, in_valid, res_ready, bus_in,
        output in_ready, bus_out, res_data, res_valid
    );

    modport slave (
        output in_vec, in_valid, res_ready, bus_in,
        input  in_ready, bus_out, res_data, res_valid
    );
endinterface

// File: rtl/mv_stream_driver.sv
// Toggle-strobed vector transmitter: launches a 6-bit vector onto the multiplier bus,
// waits a fixed settle time, then captures the 8-bit result and returns it over valid/ready.
module mv_stream_driver #(
    parameter int SETTLE_CYCLES = 3,
    parameter int PRIME_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mv_stream_driver_if.master   stream,
    output logic                 busy,
    output logic [7:0]           txn_count
);

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int CNT_MAX = (SETTLE_CYCLES > PRIME_CYCLES) ? SETTLE_CYCLES : PRIME_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          launch, capture, done;

    // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= PRIME;
        else     state <= state_next;
    end

    // NOTE: each always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        unique case (state)
            PRIME: if (cnt == CW'(PRIME_CYCLES - 1)) state_next = IDLE;
            IDLE: begin
                if (stream.in_valid) begin
                    launch     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // res_valid is always set in HOLD, so res_ready alone completes the handshake.
                if (stream.res_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = PRIME;
        endcase
    end

    always_comb begin
        stream.in_ready = (state == IDLE);
        busy            = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            stream.bus_out   <= 8'h00;
            stream.res_data  <= 8'h00;
            stream.res_valid <= 1'b0;
            txn_count        <= 8'h00;
        end else begin
            if (state == PRIME || state == WAIT) cnt <= cnt + CW'(1);
            if (launch) begin
                cnt            <= '0;
                // Bit 1 stays 0; bit 0 flips so the multiplier sees a fresh strobe even for a repeated vector.
                stream.bus_out <= {stream.in_vec, 1'b0, ~stream.bus_out[0]};
            end
            if (capture) begin
                stream.res_data  <= stream.bus_in;
                stream.res_valid <= 1'b1;
            end
            if (done) begin
                stream.res_valid <= 1'b0;
                txn_count        <= txn_count + 8'd1;
            end
        end
    end

endmodule
